// File: rtl/inst_encoder.sv
// inst_encoder: streaming RV32I instruction assembler. Packs decoded fields into a
// 32-bit word through a two-stage valid/ready pipeline and flags unrepresentable immediates.
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       imm_sel,
    input  logic [6:0]       opcode,
    input  logic [4:0]       rd,
    input  logic [4:0]       rs1,
    input  logic [4:0]       rs2,
    input  logic [2:0]       funct3,
    input  logic [6:0]       funct7,
    input  logic [31:0]      imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      inst,
    output logic             err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [2:0] SEL_I = 3'b000;
    localparam logic [2:0] SEL_B = 3'b001;
    localparam logic [2:0] SEL_U = 3'b010;
    localparam logic [2:0] SEL_J = 3'b011;
    localparam logic [2:0] SEL_S = 3'b100;
    localparam logic [2:0] SEL_R = 3'b101;

    // An immediate fits when every bit above the format's top bit copies the sign.
    function automatic logic imm_err(input logic [2:0] sel, input logic [31:0] val);
        logic e;
        case (sel)
            SEL_I, SEL_S: e = !((val[31:11] == 21'h0) || (val[31:11] == 21'h1F_FFFF));
            SEL_B:        e = val[0] || !((val[31:12] == 20'h0) || (val[31:12] == 20'hF_FFFF));
            SEL_J:        e = val[0] || !((val[31:20] == 12'h0) || (val[31:20] == 12'hFFF));
            SEL_U:        e = (val[11:0] != 12'h0);
            SEL_R:        e = 1'b0;
            default:      e = 1'b1;
        endcase
        return e;
    endfunction

    // Illegal selects fall back to I packing so the word is still emitted.
    function automatic logic [31:0] pack(
        input logic [2:0]  sel,
        input logic [6:0]  op,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_rs1,
        input logic [4:0]  f_rs2,
        input logic [2:0]  f3,
        input logic [6:0]  f7,
        input logic [31:0] val
    );
        logic [31:0] w;
        case (sel)
            SEL_S:   w = {val[11:5], f_rs2, f_rs1, f3, val[4:0], op};
            SEL_B:   w = {val[12], val[10:5], f_rs2, f_rs1, f3, val[4:1], val[11], op};
            SEL_U:   w = {val[31:12], f_rd, op};
            SEL_J:   w = {val[20], val[10:1], val[11], val[19:12], f_rd, op};
            SEL_R:   w = {f7, f_rs2, f_rs1, f3, f_rd, op};
            default: w = {val[11:0], f_rs1, f3, f_rd, op};
        endcase
        return w;
    endfunction

    logic             s1_valid_r;
    logic [2:0]       s1_sel_r;
    logic [6:0]       s1_opcode_r;
    logic [4:0]       s1_rd_r;
    logic [4:0]       s1_rs1_r;
    logic [4:0]       s1_rs2_r;
    logic [2:0]       s1_funct3_r;
    logic [6:0]       s1_funct7_r;
    logic [31:0]      s1_imm_r;
    logic             s1_err_r;
    logic             s2_valid_r;
    logic [31:0]      inst_r;
    logic             err_r;
    logic [CNT_W-1:0] enc_count_r;
    logic [CNT_W-1:0] err_count_r;
    logic             s1_adv_s;
    logic             in_fire_s;
    logic             out_fire_s;

    assign s1_adv_s   = !s2_valid_r || out_ready;
    assign in_ready   = !s1_valid_r || s1_adv_s;
    assign in_fire_s  = in_valid && in_ready;
    assign out_fire_s = s2_valid_r && out_ready;

    assign out_valid  = s2_valid_r;
    assign inst       = inst_r;
    assign err        = err_r;
    assign enc_count  = enc_count_r;
    assign err_count  = err_count_r;

    // Stage 1: capture input fields and the range check.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r  <= 1'b0;
            s1_sel_r    <= 3'b000;
            s1_opcode_r <= 7'h00;
            s1_rd_r     <= 5'h00;
            s1_rs1_r    <= 5'h00;
            s1_rs2_r    <= 5'h00;
            s1_funct3_r <= 3'b000;
            s1_funct7_r <= 7'h00;
            s1_imm_r    <= 32'h0;
            s1_err_r    <= 1'b0;
        end else if (in_ready) begin
            s1_valid_r <= in_valid;
            if (in_fire_s) begin
                s1_sel_r    <= imm_sel;
                s1_opcode_r <= opcode;
                s1_rd_r     <= rd;
                s1_rs1_r    <= rs1;
                s1_rs2_r    <= rs2;
                s1_funct3_r <= funct3;
                s1_funct7_r <= funct7;
                s1_imm_r    <= imm;
                s1_err_r    <= imm_err(imm_sel, imm);
            end
        end
    end

    // Stage 2: assembled word and error flag, held until the consumer takes them.
    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_r <= 1'b0;
            inst_r     <= 32'h0;
            err_r      <= 1'b0;
        end else if (s1_adv_s) begin
            s2_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                inst_r <= pack(s1_sel_r, s1_opcode_r, s1_rd_r, s1_rs1_r, s1_rs2_r,
                               s1_funct3_r, s1_funct7_r, s1_imm_r);
                err_r  <= s1_err_r;
            end
        end
    end

    // Saturating delivery counters; they stop at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            enc_count_r <= {CNT_W{1'b0}};
            err_count_r <= {CNT_W{1'b0}};
        end else if (out_fire_s) begin
            if (!(&enc_count_r)) begin
                enc_count_r <= enc_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
            if (err_r && !(&err_count_r)) begin
                err_count_r <= err_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule
